// File: rtl/neighbor_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | neighbor_counter_pkg : mine encoding, FSM states, neighbour offset table    |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
package neighbor_counter_pkg;

  localparam logic [4:0] MINE_VAL   = 5'h1F;
  localparam logic [3:0] c_IDX_LAST = 4'd8;

  localparam logic signed [1:0] c_M1 = 2'sb11;
  localparam logic signed [1:0] c_Z0 = 2'sb00;
  localparam logic signed [1:0] c_P1 = 2'sb01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } nbr_ofs_t;

  // idx 0 is the centre; 1..8 walk the ring starting top-left, row by row.
  function automatic nbr_ofs_t nbr_offset(input logic [3:0] idx);
    nbr_ofs_t o;
    case (idx)
      4'd1:    o = '{dx: c_M1, dy: c_M1};
      4'd2:    o = '{dx: c_Z0, dy: c_M1};
      4'd3:    o = '{dx: c_P1, dy: c_M1};
      4'd4:    o = '{dx: c_M1, dy: c_Z0};
      4'd5:    o = '{dx: c_P1, dy: c_Z0};
      4'd6:    o = '{dx: c_M1, dy: c_P1};
      4'd7:    o = '{dx: c_Z0, dy: c_P1};
      4'd8:    o = '{dx: c_P1, dy: c_P1};
      default: o = '{dx: c_Z0, dy: c_Z0};
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/neighbor_counter_nbr_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nbr_addr_gen : combinational (cx,cy,idx) -> bounded board read address     |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module nbr_addr_gen #(
  parameter int x_size       = 16,
  parameter int y_size       = 16,
  parameter int x_coord_bits = 4,
  parameter int y_coord_bits = 4
) (
  input  logic [x_coord_bits-1:0] cx,
  input  logic [y_coord_bits-1:0] cy,
  input  logic [3:0]              idx,
  output logic [x_coord_bits-1:0] rd_x,
  output logic [y_coord_bits-1:0] rd_y,
  output logic                    valid,
  output logic                    is_centre
);
  import neighbor_counter_pkg::*;

  localparam int XW = x_coord_bits + 2;
  localparam int YW = y_coord_bits + 2;
  localparam logic signed [XW-1:0] c_X_LIM = XW'(x_size);
  localparam logic signed [YW-1:0] c_Y_LIM = YW'(y_size);

  nbr_ofs_t             w_ofs;
  logic signed [XW-1:0] w_nx;
  logic signed [YW-1:0] w_ny;
  logic                 w_x_ok;
  logic                 w_y_ok;

  // Out-of-range slots fall back to the centre address so the read stays legal.
  always_comb begin
    w_ofs     = nbr_offset(idx);
    w_nx      = $signed({2'b00, cx}) + $signed({{x_coord_bits{w_ofs.dx[1]}}, w_ofs.dx});
    w_ny      = $signed({2'b00, cy}) + $signed({{y_coord_bits{w_ofs.dy[1]}}, w_ofs.dy});
    w_x_ok    = !w_nx[XW-1] && (w_nx < c_X_LIM);
    w_y_ok    = !w_ny[YW-1] && (w_ny < c_Y_LIM);
    valid     = w_x_ok && w_y_ok;
    is_centre = (idx == 4'd0);
    rd_x      = valid ? w_nx[x_coord_bits-1:0] : cx;
    rd_y      = valid ? w_ny[y_coord_bits-1:0] : cy;
  end

endmodule
`default_nettype wire

// File: rtl/neighbor_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | neighbor_counter : sweeps the board and writes mine marker or 0..8 counts   |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module neighbor_counter #(
  parameter int         x_size       = 16,
  parameter int         y_size       = 16,
  parameter int         x_coord_bits = 4,
  parameter int         y_coord_bits = 4,
  parameter logic [4:0] MINE_VAL     = neighbor_counter_pkg::MINE_VAL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [x_coord_bits-1:0] rd_x,
  output logic [y_coord_bits-1:0] rd_y,
  input  logic [4:0]              cell_val,
  output logic                    wr_en,
  output logic [x_coord_bits-1:0] wr_x,
  output logic [y_coord_bits-1:0] wr_y,
  output logic [4:0]              wr_val,
  output logic                    busy,
  output logic                    done
);
  import neighbor_counter_pkg::*;

  localparam logic [x_coord_bits-1:0] c_X_LAST = x_coord_bits'(x_size - 1);
  localparam logic [y_coord_bits-1:0] c_Y_LAST = y_coord_bits'(y_size - 1);

  state_t                  r_state, w_state_nxt;
  logic [x_coord_bits-1:0] r_cx, w_cx_nxt;
  logic [y_coord_bits-1:0] r_cy, w_cy_nxt;
  logic [3:0]              r_idx, w_idx_nxt;
  logic [3:0]              r_count, w_count_nxt;
  logic                    r_is_mine, w_is_mine_nxt;

  logic                    r_cur_vld, r_cur_ctr;
  logic                    r_ret_scan, r_ret_vld, r_ret_ctr;

  logic [x_coord_bits-1:0] w_rd_x;
  logic [y_coord_bits-1:0] w_rd_y;
  logic                    w_vld, w_ctr;
  logic                    w_last_cell;

  // Fed with next-cycle coordinates so the registered address lines up with the SCAN slot.
  nbr_addr_gen #(
    .x_size      (x_size),
    .y_size      (y_size),
    .x_coord_bits(x_coord_bits),
    .y_coord_bits(y_coord_bits)
  ) u_addr_gen (
    .cx       (w_cx_nxt),
    .cy       (w_cy_nxt),
    .idx      (w_idx_nxt),
    .rd_x     (w_rd_x),
    .rd_y     (w_rd_y),
    .valid    (w_vld),
    .is_centre(w_ctr)
  );

  assign w_last_cell = (r_cx == c_X_LAST) && (r_cy == c_Y_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_cx_nxt      = r_cx;
    w_cy_nxt      = r_cy;
    w_idx_nxt     = r_idx;
    w_count_nxt   = r_count;
    w_is_mine_nxt = r_is_mine;

    if (r_ret_scan) begin
      if (r_ret_ctr) begin
        w_is_mine_nxt = (cell_val == MINE_VAL);
      end else if (r_ret_vld && (cell_val == MINE_VAL)) begin
        w_count_nxt = r_count + 4'd1;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SCAN;
          w_cx_nxt    = '0;
          w_cy_nxt    = '0;
          w_idx_nxt   = '0;
          w_count_nxt = '0;
        end
      end
      ST_SCAN: begin
        if (r_idx == c_IDX_LAST) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_idx_nxt = r_idx + 4'd1;
        end
      end
      ST_DRAIN: w_state_nxt = ST_WRITE;
      ST_WRITE: begin
        w_idx_nxt   = '0;
        w_count_nxt = '0;
        if (w_last_cell) begin
          w_state_nxt = ST_FINISH;
          w_cx_nxt    = '0;
          w_cy_nxt    = '0;
        end else begin
          w_state_nxt = ST_SCAN;
          if (r_cx == c_X_LAST) begin
            w_cx_nxt = '0;
            w_cy_nxt = r_cy + 1'b1;
          end else begin
            w_cx_nxt = r_cx + 1'b1;
          end
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cx       <= '0;
      r_cy       <= '0;
      r_idx      <= '0;
      r_count    <= '0;
      r_is_mine  <= 1'b0;
      r_cur_vld  <= 1'b0;
      r_cur_ctr  <= 1'b0;
      r_ret_scan <= 1'b0;
      r_ret_vld  <= 1'b0;
      r_ret_ctr  <= 1'b0;
      rd_x       <= '0;
      rd_y       <= '0;
      wr_en      <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_val     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cx       <= w_cx_nxt;
      r_cy       <= w_cy_nxt;
      r_idx      <= w_idx_nxt;
      r_count    <= w_count_nxt;
      r_is_mine  <= w_is_mine_nxt;
      r_cur_vld  <= w_vld;
      r_cur_ctr  <= w_ctr;
      r_ret_scan <= (r_state == ST_SCAN);
      r_ret_vld  <= r_cur_vld;
      r_ret_ctr  <= r_cur_ctr;
      rd_x       <= w_rd_x;
      rd_y       <= w_rd_y;
      wr_en      <= (w_state_nxt == ST_WRITE);
      // The last neighbour return lands in DRAIN, so the write uses the next-count.
      if (w_state_nxt == ST_WRITE) begin
        wr_x   <= r_cx;
        wr_y   <= r_cy;
        wr_val <= w_is_mine_nxt ? MINE_VAL : {1'b0, w_count_nxt};
      end
      busy <= (w_state_nxt == ST_SCAN) || (w_state_nxt == ST_DRAIN) ||
              (w_state_nxt == ST_WRITE);
      done <= (w_state_nxt == ST_FINISH);
    end
  end

endmodule
`default_nettype wire

// File: doc/neighbor_counter.md
# neighbor_counter

Post-initialisation annotation stage directly downstream of the board generator. Once the board fill completes, it sweeps every cell in row-major order and reads the cell and its eight neighbours through the board's registered read port. It then emits one write per cell carrying either the mine marker or the adjacent-mine count (0–8). Its write stream feeds the board's annotation write port, and its `done` pulse releases gameplay logic.

## Interface
Parameters:
- `x_size`, 16: columns.
- `y_size`, 16: rows.
- `x_coord_bits`, 4: column index width.
- `y_coord_bits`, 4: row index width.
- `MINE_VAL`, 5'h1F: cell encoding of a mine (−1 in 5 bits).

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `start`, input, 1: single-cycle pulse requesting a sweep; sampled only in IDLE.
- `rd_x`, output, `x_coord_bits`: column address to board read port.
- `rd_y`, output, `y_coord_bits`: row address to board read port.
- `cell_val`, input, 5: board read data, valid exactly one cycle after the address.
- `wr_en`, output, 1: write strobe, one cycle per cell.
- `wr_x`, output, `x_coord_bits`: write column.
- `wr_y`, output, `y_coord_bits`: write row.
- `wr_val`, output, 5: `MINE_VAL` or `{1'b0, count[3:0]}`.
- `busy`, output, 1: high from the cycle after an accepted `start` until `done`.
- `done`, output, 1: one-cycle pulse after the final write.

## Operation
- States: IDLE, SCAN, DRAIN, WRITE, FINISH.
- IDLE to SCAN on `start`. Cell counters `cx` and `cy` are set to 0, and `idx` and `count` are cleared.
- **SCAN** (`idx` 0..8, one per cycle):
  - `idx` 0 addresses the centre cell (cx, cy).
  - `idx` 1..8 address the neighbour offsets in this fixed order: (−1,−1), (0,−1), (+1,−1), (−1,0), (+1,0), (−1,+1), (0,+1), (+1,+1).
  - An out-of-range offset (x<0, x≥x_size, y<0, y≥y_size) drives the centre address. Its valid flag is 0.
  - `idx`, the valid flag, and the is-centre flag are delayed one cycle to align with `cell_val`.
- Accumulation, on each aligned return:
  - If is-centre: `is_mine <= (cell_val == MINE_VAL)`.
  - Otherwise, if valid and `cell_val == MINE_VAL`: `count <= count + 1`.
  - `count` is 4 bits, max 8, and never saturates.
- SCAN goes to DRAIN after `idx` 8. DRAIN absorbs the `idx` 8 return.
- **WRITE**:
  - `wr_en` = 1; `wr_x`/`wr_y` = cx/cy.
  - `wr_val` = `MINE_VAL` if `is_mine`, else `{1'b0, count}`.
  - Then advance (cx,cy) row-major, clear `count`/`idx`, and return to SCAN. After cell (x_size−1, y_size−1), go to FINISH.
- FINISH: `done` = 1 for one cycle, then IDLE.
- `start` is ignored outside IDLE.
- `cell_val` values other than `MINE_VAL` count as non-mines. A mine cell's own count is discarded.

## Timing
- Reset values:
  - State IDLE.
  - `rd_x`, `rd_y`, `wr_x`, `wr_y`, `wr_val`, `count`, `idx`, `cx`, `cy` = 0.
  - `wr_en`, `busy`, `done`, `is_mine` = 0.
- Reset asserted mid-sweep aborts immediately. No further `wr_en`, no `done`.
- Per-cell cost is 11 cycles: 9 SCAN, 1 DRAIN, 1 WRITE. Out-of-range slots still consume their cycle.
- Full sweep is x_size·y_size·11 + 1 cycles from the first SCAN cycle to `done`. For 16×16 that is 2817 cycles.
- `start` at edge N: first SCAN address appears at cycle N+1, first `wr_en` at N+11.
- All outputs are registered. `rd_x`/`rd_y` are stable for the whole cycle they are issued.
- `start` coincident with `done` is ignored: the state is FINISH, not IDLE.

## Structure
- Shared package holds:
  - `MINE_VAL`.
  - State encoding (IDLE/SCAN/DRAIN/WRITE/FINISH).
  - Neighbour offset table (index → signed dx, dy).
- One sub-module, `nbr_addr_gen`: combinational. Takes (cx, cy, idx) and produces (rd_x, rd_y, valid, is_centre), with bounds checks against `x_size`/`y_size`.
- The top level holds the FSM, counters, alignment pipeline register and write register.

## Test plan
- All-zero board, `start` pulse → 256 writes, all `wr_val` = 0, in row-major order. `done` at 2817 cycles after the first SCAN. `busy` falls with `done`.
- Single mine at (5,5) → (5,5) writes 5'h1F. Its 8 neighbours write 1. All other cells write 0.
- All-mine board → every write is 5'h1F.
- Corner check: mines at (1,0), (0,1), (1,1) only → (0,0) writes 3; out-of-range slots never increment.
- Reset asserted at cycle 500 of a sweep → all outputs return to 0 in the same cycle. No `wr_en` and no `done` follow. A fresh `start` then completes normally.
- `start` pulsed repeatedly while busy → exactly 256 writes and a single `done`.
